safe_softmax_exp_stage: RTL and testbench

- Front half of the safe-softmax datapath for one vector of N scores.
- Buffers the vector, tracks the running maximum, then streams out e^(x_i - max) per element.
- Each exponent is computed as 2^-(k+f): the 13-bit fraction f indexes one instance of safe_softmax_lut_neg, and the LUT result is shifted right by the integer part k.
- Also produces the running sum of the exponentials, which the normalisation stage downstream consumes.

---
 rtl/safe_softmax_exp_stage_if.sv | 30 +++
 rtl/safe_softmax_exp_stage.sv | 204 ++++++++++++++++++++
 tb/tb_safe_softmax_exp_stage.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/safe_softmax_exp_stage_if.sv
// Bus bundle for the safe-softmax exponent stage: score input stream, exponent output
// stream, captured maximum and a state debug bit.
interface safe_softmax_exp_stage_if #(
    parameter int D_W    = 16,
    parameter int ADDR_W = 4
);
    // Both streams use the same valid/ready rule: a transfer happens on a rising clock edge
    // where valid and ready are both high. Once valid is raised, the payload stays stable until
    // that edge. O_X_READY depends only on the stage's state, never on I_X_VALID.
    logic                  I_X_VALID;
    logic                  O_X_READY;
    logic [D_W-1:0]        I_X;
    logic                  O_E_VALID;
    logic                  I_E_READY;
    logic [D_W-1:0]        O_E;
    logic                  O_E_LAST;
    logic [D_W+ADDR_W-1:0] O_E_SUM;
    logic [D_W-1:0]        O_MAX;
    logic                  O_STATE;

    modport master (
        output I_X_VALID, I_X, I_E_READY,
        input  O_X_READY, O_E_VALID, O_E, O_E_LAST, O_E_SUM, O_MAX, O_STATE
    );

    modport slave (
        input  I_X_VALID, I_X, I_E_READY,
        output O_X_READY, O_E_VALID, O_E, O_E_LAST, O_E_SUM, O_MAX, O_STATE
    );
endinterface

// File: rtl/safe_softmax_exp_stage.sv
// Exponent stage of a safe softmax: buffers N Q2.13 scores, captures their maximum, then
// streams e^(x_i - max) computed as 2^-(k+f), together with the running sum of the outputs.
module safe_softmax_exp_stage #(
    parameter int D_W    = 16,
    parameter int N      = 16,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic                    I_CLK,
    input  logic                    I_RST,
    safe_softmax_exp_stage_if.slave bus
);
    typedef enum logic {
        S_LOAD = 1'b0,
        S_EXP  = 1'b1
    } state_t;

    localparam int IDX_W = (ADDR_W > 0) ? ADDR_W : 1;
    localparam int CNT_W = $clog2(N + 1);
    localparam int SUM_W = D_W + ADDR_W;
    localparam int P_W   = D_W + 14;
    localparam int T_W   = D_W + 1;
    localparam int K_W   = T_W - 13;

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [P_W-1:0]   LOG2E_Q13 = P_W'(11819);
    localparam logic [K_W-1:0]   K_MAX     = K_W'(14);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [D_W-1:0]     max_q, max_d;
    logic [D_W-1:0]     e_q, e_d;
    logic [SUM_W-1:0]   e_sum_q, e_sum_d;
    logic               e_last_q, e_last_d;
    logic               e_valid_q, e_valid_d;
    logic [D_W-1:0]     buf_q [N];

    logic               x_hs;
    logic               slot_free;
    logic               can_load;
    logic               last_acc;
    logic [D_W-1:0]     rd_data;
    logic [D_W-1:0]     diff;
    logic [P_W-1:0]     prod;
    logic [T_W-1:0]     t_val;
    logic [K_W-1:0]     k_val;
    logic [12:0]        f_val;
    logic [D_W-1:0]     lut_val;
    logic [D_W-1:0]     e_val;
    logic [11:0]        unused_prod;

    assign x_hs      = bus.I_X_VALID && (state_q == S_LOAD);
    assign slot_free = !e_valid_q || bus.I_E_READY;
    assign can_load  = (state_q == S_EXP) && (rd_cnt_q <= LAST_IDX);
    assign last_acc  = e_valid_q && bus.I_E_READY && e_last_q;

    // The difference wraps into an unsigned value, so the full signed span maps onto 0..65535.
    assign rd_data     = buf_q[rd_cnt_q[IDX_W-1:0]];
    assign diff        = max_q - rd_data;
    assign prod        = P_W'(diff) * LOG2E_Q13;
    assign t_val       = prod[P_W-1:13] + T_W'(prod[12]);
    assign k_val       = t_val[T_W-1:13];
    assign f_val       = t_val[12:0];
    assign unused_prod = prod[11:0];

    safe_softmax_lut_neg u_lut (
        .vi (f_val),
        .vo (lut_val)
    );

    assign e_val = (k_val >= K_MAX) ? '0 : (lut_val >> k_val);

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        max_d     = max_q;
        e_d       = e_q;
        e_sum_d   = e_sum_q;
        e_last_d  = e_last_q;
        e_valid_d = e_valid_q;
        case (state_q)
            S_LOAD: begin
                if (x_hs) begin
                    if ((wr_cnt_q == '0) || ($signed(bus.I_X) > $signed(max_q))) begin
                        max_d = bus.I_X;
                    end
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                        state_d  = S_EXP;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CNT_ONE;
                    end
                end
            end
            S_EXP: begin
                if (slot_free && can_load) begin
                    e_d       = e_val;
                    e_sum_d   = (rd_cnt_q == '0) ? SUM_W'(e_val) : e_sum_q + SUM_W'(e_val);
                    e_last_d  = (rd_cnt_q == LAST_IDX);
                    e_valid_d = 1'b1;
                    rd_cnt_d  = rd_cnt_q + CNT_ONE;
                end else if (slot_free) begin
                    e_valid_d = 1'b0;
                    e_last_d  = 1'b0;
                end
                // Loading and accepting the last element never coincide: rd_cnt is already N.
                if (last_acc) begin
                    state_d  = S_LOAD;
                    rd_cnt_d = '0;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q   <= S_LOAD;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            max_q     <= '0;
            e_q       <= '0;
            e_sum_q   <= '0;
            e_last_q  <= 1'b0;
            e_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            max_q     <= max_d;
            e_q       <= e_d;
            e_sum_q   <= e_sum_d;
            e_last_q  <= e_last_d;
            e_valid_q <= e_valid_d;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (x_hs) begin
            buf_q[wr_cnt_q[IDX_W-1:0]] <= bus.I_X;
        end
    end

    assign bus.O_X_READY = (state_q == S_LOAD);
    assign bus.O_E_VALID = e_valid_q;
    assign bus.O_E       = e_q;
    assign bus.O_E_LAST  = e_last_q;
    assign bus.O_E_SUM   = e_sum_q;
    assign bus.O_MAX     = max_q;
    assign bus.O_STATE   = state_q;
endmodule

// 2^-f for f in [0,1) in Q0.13 steps, 8192 = 1.0; the top five fraction bits select one of
// 32 entries round(8192 * 2^(-i/32)).
module safe_softmax_lut_neg (
    input  logic [12:0] vi,
    output logic [15:0] vo
);
    logic [7:0] unused_frac;

    assign unused_frac = vi[7:0];

    always_comb begin
        vo = 16'd8192;
        case (vi[12:8])
            5'd0:  vo = 16'd8192;
            5'd1:  vo = 16'd8016;
            5'd2:  vo = 16'd7845;
            5'd3:  vo = 16'd7677;
            5'd4:  vo = 16'd7512;
            5'd5:  vo = 16'd7351;
            5'd6:  vo = 16'd7194;
            5'd7:  vo = 16'd7039;
            5'd8:  vo = 16'd6889;
            5'd9:  vo = 16'd6741;
            5'd10: vo = 16'd6597;
            5'd11: vo = 16'd6455;
            5'd12: vo = 16'd6317;
            5'd13: vo = 16'd6182;
            5'd14: vo = 16'd6049;
            5'd15: vo = 16'd5919;
            5'd16: vo = 16'd5793;
            5'd17: vo = 16'd5668;
            5'd18: vo = 16'd5547;
            5'd19: vo = 16'd5428;
            5'd20: vo = 16'd5312;
            5'd21: vo = 16'd5198;
            5'd22: vo = 16'd5087;
            5'd23: vo = 16'd4978;
            5'd24: vo = 16'd4871;
            5'd25: vo = 16'd4767;
            5'd26: vo = 16'd4664;
            5'd27: vo = 16'd4565;
            5'd28: vo = 16'd4467;
            5'd29: vo = 16'd4371;
            5'd30: vo = 16'd4277;
            5'd31: vo = 16'd4186;
            default: vo = 16'd8192;
        endcase
    end
endmodule

// File: tb/tb_safe_softmax_exp_stage.sv
// Bench for safe_softmax_exp_stage: vector table plus hand-written stall, reset and
// input-during-output sequences, all checked through an expected-output queue.
module tb_safe_softmax_exp_stage;
  localparam int D_W = 16;
  localparam int N = 16;
  localparam int ADDR_W = 4;
  localparam int SUM_W = D_W + ADDR_W;
  localparam int EW = 1 + SUM_W + D_W;
  localparam int NV = 5;

  typedef logic [N-1:0][D_W-1:0] vec_t;
  typedef struct packed {
    vec_t x;
    logic [D_W-1:0] exp_max;
    logic [SUM_W-1:0] exp_sum;
    logic [D_W-1:0] exp_e1;
    logic hand;
    logic rnd_ready;
  } vec_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;
  int out_idx = 0;
  logic [SUM_W-1:0] last_sum = '0;
  logic [D_W-1:0] out_log [N];
  logic [EW-1:0] exp_q [$];
  vec_rec_t tbl [NV];

  safe_softmax_exp_stage_if #(.D_W(D_W), .ADDR_W(ADDR_W)) bus ();

  safe_softmax_exp_stage #(.D_W(D_W), .N(N), .ADDR_W(ADDR_W)) dut (
    .I_CLK(clk),
    .I_RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference exponent: independent real-valued table entry, shifted by the integer part.
  function automatic logic [D_W-1:0] model_e(input logic [D_W-1:0] x, input logic [D_W-1:0] mx);
    logic [D_W-1:0] d;
    longint p;
    longint t;
    int k;
    int idx;
    int lut;
    d = mx - x;
    p = longint'(d) * 64'd11819;
    t = (p >> 13) + ((p >> 12) & 64'd1);
    k = int'(t >> 13);
    idx = int'((t & 64'd8191) >> 8);
    lut = $rtoi(8192.0 * (2.0 ** (-real'(idx) / 32.0)) + 0.5);
    return (k >= 14) ? '0 : D_W'(lut >> k);
  endfunction

  function automatic logic [D_W-1:0] vec_max(input vec_t v);
    logic [D_W-1:0] m;
    m = v[0];
    for (int i = 1; i < N; i++) if ($signed(v[i]) > $signed(m)) m = v[i];
    return m;
  endfunction

  function automatic logic [SUM_W-1:0] vec_sum(input vec_t v);
    logic [SUM_W-1:0] s;
    logic [D_W-1:0] m;
    s = '0;
    m = vec_max(v);
    for (int i = 0; i < N; i++) s = s + SUM_W'(model_e(v[i], m));
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    logic [EW-1:0] w;
    forever begin
      @(negedge clk);
      if (mon_en && bus.O_E_VALID) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got e=%0d sum=%0d, expected no output", bus.O_E, bus.O_E_SUM);
        end else begin
          w = {bus.O_E_LAST, bus.O_E_SUM, bus.O_E};
          check($sformatf("out[%0d] {last,sum,e}", out_idx), 64'(w), 64'(exp_q[0]));
          if (bus.I_E_READY) begin
            if (out_idx < N) out_log[out_idx] = bus.O_E;
            if (bus.O_E_LAST) last_sum = bus.O_E_SUM;
            out_idx++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  endtask

  task automatic drive_vector(input vec_t v);
    int i;
    int guard;
    logic [D_W-1:0] m;
    logic [D_W-1:0] e;
    logic [SUM_W-1:0] s;
    i = 0;
    guard = 0;
    out_idx = 0;
    last_sum = '0;
    while (i < N && guard < 200) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.I_X_VALID = 1'b0;
        @(posedge clk); #1;
      end
      bus.I_X_VALID = 1'b1;
      bus.I_X = v[i];
      @(negedge clk);
      if (bus.O_X_READY) i++;
      @(posedge clk); #1;
      guard++;
    end
    bus.I_X_VALID = 1'b0;
    if (i < N) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got %0d handshakes, expected %0d", i, N);
    end
    m = vec_max(v);
    s = '0;
    for (int j = 0; j < N; j++) begin
      e = model_e(v[j], m);
      s = s + SUM_W'(e);
      exp_q.push_back({(j == N - 1), s, e});
    end
  endtask

  task automatic wait_drain(input bit rnd);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      bus.I_E_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    bus.I_E_READY = 1'b1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outputs pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_vector(input vec_rec_t r, input string tag);
    check({tag, " ready_after_last"}, 64'(bus.O_X_READY), 64'd1);
    check({tag, " valid_after_last"}, 64'(bus.O_E_VALID), 64'd0);
    check({tag, " max"}, 64'(bus.O_MAX), 64'(r.exp_max));
    check({tag, " final_sum"}, 64'(last_sum), 64'(r.exp_sum));
    check({tag, " out_count"}, 64'(out_idx), 64'(N));
    if (r.hand) check({tag, " e1"}, 64'(out_log[1]), 64'(r.exp_e1));
  endtask

  initial begin
    int cyc;
    bus.I_X_VALID = 1'b0;
    bus.I_X = '0;
    bus.I_E_READY = 1'b1;

    for (int i = 0; i < N; i++) tbl[0].x[i] = 16'h1000;
    tbl[0].exp_max = 16'h1000; tbl[0].exp_sum = 20'd131072; tbl[0].exp_e1 = 16'd8192;
    tbl[0].hand = 1'b1; tbl[0].rnd_ready = 1'b0;
    for (int i = 0; i < N; i++) tbl[1].x[i] = (i == 0) ? 16'h2000 : 16'h0000;
    tbl[1].exp_max = 16'h2000; tbl[1].exp_sum = 20'd53552; tbl[1].exp_e1 = 16'd3024;
    tbl[1].hand = 1'b1; tbl[1].rnd_ready = 1'b0;
    for (int i = 0; i < N; i++) tbl[2].x[i] = (i == 1) ? 16'h8000 : 16'h7FFF;
    tbl[2].exp_max = 16'h7FFF; tbl[2].exp_sum = 20'd122882; tbl[2].exp_e1 = 16'd2;
    tbl[2].hand = 1'b1; tbl[2].rnd_ready = 1'b1;
    for (int t = 3; t < NV; t++) begin
      for (int i = 0; i < N; i++) tbl[t].x[i] = 16'($urandom);
      tbl[t].exp_max = vec_max(tbl[t].x);
      tbl[t].exp_sum = vec_sum(tbl[t].x);
      tbl[t].exp_e1 = model_e(tbl[t].x[1], tbl[t].exp_max);
      tbl[t].hand = 1'b0;
      tbl[t].rnd_ready = 1'b1;
    end

    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset x_ready", 64'(bus.O_X_READY), 64'd1);
    check("reset e_valid", 64'(bus.O_E_VALID), 64'd0);
    check("reset e", 64'(bus.O_E), 64'd0);
    check("reset e_sum", 64'(bus.O_E_SUM), 64'd0);
    check("reset e_last", 64'(bus.O_E_LAST), 64'd0);
    check("reset max", 64'(bus.O_MAX), 64'd0);
    @(posedge clk); #1;

    for (int t = 0; t < NV; t++) begin
      drive_vector(tbl[t].x);
      wait_drain(tbl[t].rnd_ready);
      check_vector(tbl[t], $sformatf("vec%0d", t));
    end

    // Three-cycle stall while output 5 is presented.
    drive_vector(tbl[1].x);
    cyc = 0;
    while (out_idx < 5 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stall reached_out5", 64'(out_idx), 64'd5);
    bus.I_E_READY = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.I_E_READY = 1'b1;
    wait_drain(1'b0);
    check_vector(tbl[1], "stall");

    // Reset pulse while output 7 is presented, then a fresh vector.
    drive_vector(tbl[1].x);
    cyc = 0;
    while (out_idx < 7 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("midreset reached_out7", 64'(out_idx), 64'd7);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset e_valid", 64'(bus.O_E_VALID), 64'd0);
    check("midreset e_sum", 64'(bus.O_E_SUM), 64'd0);
    check("midreset e_last", 64'(bus.O_E_LAST), 64'd0);
    check("midreset x_ready", 64'(bus.O_X_READY), 64'd1);
    exp_q.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;
    drive_vector(tbl[2].x);
    wait_drain(1'b0);
    check_vector(tbl[2], "after_reset");

    // Keep presenting changing data during the output phase.
    drive_vector(tbl[0].x);
    cyc = 0;
    bus.I_X_VALID = 1'b1;
    while (!bus.O_X_READY && cyc < 200) begin
      bus.I_X = 16'($urandom_range(16'h2001, 16'h7FFF));
      @(negedge clk);
      check("busy max_hold", 64'(bus.O_MAX), 64'h1000);
      @(posedge clk); #1;
      cyc++;
    end
    check("busy outputs_done", 64'(exp_q.size()), 64'd0);
    check("busy last_sum", 64'(last_sum), 64'(tbl[0].exp_sum));
    drive_vector(tbl[1].x);
    wait_drain(1'b0);
    check_vector(tbl[1], "after_busy");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
